// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access size encodings,
// default bus/memory dimensions and the controller state type.
package lsu_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int MEM_BYTES = 256;

  localparam logic [1:0] WORD      = 2'b10;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] BYTE      = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ACCESS,
    SPLIT,
    RESP
  } lsu_state_e;

  // Index of the last byte touched by an access (nbytes - 1); 2'b11 behaves as a word.
  function automatic logic [1:0] size_last_byte(input logic [1:0] size);
    case (size)
      BYTE:      return 2'd0;
      HALF_WORD: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational helper: merges a freshly read byte into the partial load result
// and applies sign/zero extension for sub-word loads.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int DW = lsu_pkg::BUS_WIDTH
) (
  input  logic [DW-1:0] result_in,
  input  logic [7:0]    byte_in,
  input  logic [1:0]    byte_idx,
  input  logic [1:0]    size,
  input  logic          sz_ex,
  output logic [DW-1:0] assembled,
  output logic [DW-1:0] extended
);

  always_comb begin
    assembled = result_in;
    assembled[{byte_idx, 3'b000} +: 8] = byte_in;
  end

  // Split word loads already hold every byte, so only sub-word sizes are extended.
  always_comb begin
    case (size)
      HALF_WORD: extended = {{(DW-16){sz_ex & assembled[15]}}, assembled[15:0]};
      BYTE:      extended = {{(DW-8){sz_ex & assembled[7]}}, assembled[7:0]};
      default:   extended = assembled;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, range-checks it, then issues
// either a single aligned memory access or a sequence of byte accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int BUS_WIDTH = lsu_pkg::BUS_WIDTH,
  parameter int MEM_BYTES = lsu_pkg::MEM_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  input  logic [1:0]           req_size,
  input  logic                 req_sz_ex,

  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,

  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_data_in,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_data_out
);

  lsu_state_e state_q, state_d;

  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0] result_q, result_d;
  logic [1:0]           size_q, size_d;
  logic                 sz_ex_q, sz_ex_d;
  logic                 wr_q, wr_d;
  logic [1:0]           cnt_q, cnt_d;

  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [BUS_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic [BUS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [BUS_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 mem_sz_ex_q, mem_sz_ex_d;

  logic [1:0]           last_idx;
  logic [1:0]           cnt_next;
  logic [BUS_WIDTH:0]   end_addr;
  logic                 range_err;
  logic                 aligned;
  logic [BUS_WIDTH-1:0] split_word;
  logic [BUS_WIDTH-1:0] split_rdata;

  // One extra bit on the end address so accesses near the top of the space cannot wrap.
  always_comb begin
    last_idx  = size_last_byte(size_q);
    cnt_next  = cnt_q + 2'd1;
    end_addr  = {1'b0, addr_q} + {{(BUS_WIDTH-1){1'b0}}, last_idx};
    range_err = (end_addr >= (BUS_WIDTH+1)'(MEM_BYTES));
    aligned   = (size_q == BYTE)
             || ((size_q == HALF_WORD) && !addr_q[0])
             || ((size_q == WORD) && (addr_q[1:0] == 2'b00));
  end

  lsu_extend #(
    .DW(BUS_WIDTH)
  ) u_extend (
    .result_in (result_q),
    .byte_in   (mem_data_out[7:0]),
    .byte_idx  (cnt_q),
    .size      (size_q),
    .sz_ex     (sz_ex_q),
    .assembled (split_word),
    .extended  (split_rdata)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    sz_ex_d       = sz_ex_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_size_d    = mem_size_q;
    mem_sz_ex_d   = mem_sz_ex_q;
    mem_wr_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size;
          sz_ex_d  = req_sz_ex;
          wr_d     = req_wr;
          cnt_d    = 2'd0;
          result_d = '0;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        if (range_err) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (aligned) begin
          state_d       = ACCESS;
          mem_address_d = addr_q;
          mem_size_d    = size_q;
          mem_sz_ex_d   = sz_ex_q;
          mem_data_in_d = wdata_q;
          mem_wr_en_d   = wr_q;
        end else begin
          state_d       = SPLIT;
          cnt_d         = 2'd0;
          mem_address_d = addr_q;
          mem_size_d    = BYTE;
          mem_sz_ex_d   = 1'b0;
          mem_data_in_d = {{(BUS_WIDTH-8){1'b0}}, wdata_q[7:0]};
          mem_wr_en_d   = wr_q;
        end
      end

      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        if (!wr_q) begin
          result_d     = mem_data_out;
          resp_rdata_d = mem_data_out;
        end
      end

      // Each SPLIT cycle retires byte cnt_q and, unless it was the last, sets up the next one.
      SPLIT: begin
        if (!wr_q) begin
          result_d = split_word;
        end
        if (cnt_q == last_idx) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (!wr_q) begin
            resp_rdata_d = split_rdata;
          end
        end else begin
          cnt_d         = cnt_next;
          mem_address_d = addr_q + {{(BUS_WIDTH-2){1'b0}}, cnt_next};
          mem_data_in_d = {{(BUS_WIDTH-8){1'b0}}, wdata_q[{cnt_next, 3'b000} +: 8]};
          mem_wr_en_d   = wr_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= WORD;
      sz_ex_q       <= 1'b0;
      wr_q          <= 1'b0;
      cnt_q         <= 2'd0;
      result_q      <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_size_q    <= WORD;
      mem_sz_ex_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      sz_ex_q       <= sz_ex_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_size_q    <= mem_size_d;
      mem_sz_ex_q   <= mem_sz_ex_d;
    end
  end

  // Gating with rst stops a write landing on the very edge that aborts an access.
  assign mem_wr_en   = mem_wr_en_q & ~rst;
  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_size    = mem_size_q;
  assign mem_sz_ex   = mem_sz_ex_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed memory model, response
// scoreboard and directed aligned/split/error/reset/busy scenarios.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } wr_rec_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_sz_ex;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_wr_en;
  logic [1:0]  mem_size;
  logic        mem_sz_ex;
  logic [31:0] mem_data_out;

  logic [7:0]  mem [0:255];
  logic        mem_clear;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_word;

  exp_t        sb_q [$];
  wr_rec_t     wr_log [$];
  int          accept_cnt = 0;
  int          resp_cnt = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;

  load_store_unit #(
    .BUS_WIDTH(32),
    .MEM_BYTES(256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_sz_ex    (req_sz_ex),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_wr_en    (mem_wr_en),
    .mem_size     (mem_size),
    .mem_sz_ex    (mem_sz_ex),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read with its own extension, byte-lane writes on the clock.
  always_comb begin
    mem_rd_addr = mem_address[7:0];
    mem_word = {mem[mem_rd_addr + 8'd3], mem[mem_rd_addr + 8'd2],
                mem[mem_rd_addr + 8'd1], mem[mem_rd_addr]};
    case (mem_size)
      BYTE:      mem_data_out = {{24{mem_sz_ex & mem_word[7]}}, mem_word[7:0]};
      HALF_WORD: mem_data_out = {{16{mem_sz_ex & mem_word[15]}}, mem_word[15:0]};
      default:   mem_data_out = mem_word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_wr_en && (mem_address < 32'd256)) begin
      wr_log.push_back('{mem_address, mem_data_in, mem_size});
      mem[mem_address[7:0]] <= mem_data_in[7:0];
      if (mem_size != BYTE) mem[mem_address[7:0] + 8'd1] <= mem_data_in[15:8];
      if (mem_size == WORD) begin
        mem[mem_address[7:0] + 8'd2] <= mem_data_in[23:16];
        mem[mem_address[7:0] + 8'd3] <= mem_data_in[31:24];
      end
    end
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) accept_cnt <= accept_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size, input logic sz_ex);
    @(negedge clk);
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_sz_ex = sz_ex;
    req_valid = 1'b1;
    check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Latency is counted in edges from the accept edge to the edge that samples resp_valid.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic sz_ex,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int   k;
    bit   got;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    apply_stimulus(tag, wr, addr, wdata, size, sz_ex);
    got = 1'b0;
    k = 0;
    while (!got && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (resp_valid) got = 1'b1;
    end
    check_output({tag, "_resp_seen"}, 32'(got), 32'd1);
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output({tag, "_rdata"}, resp_rdata, e.rdata);
      check_output({tag, "_err"}, 32'(resp_err), 32'(e.err));
      check_output({tag, "_latency"}, 32'(k + 1), 32'(e.lat));
    end
    @(posedge clk);
    #1;
    check_output({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
    check_output({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int start, input int exp_n,
                              input logic [31:0] base, input logic [31:0] exp_data,
                              input logic [1:0] sz);
    wr_rec_t r;
    check_output({tag, "_wr_count"}, 32'(wr_log.size() - start), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (start + i < wr_log.size()) begin
        r = wr_log[start + i];
        check_output({tag, "_wr_addr"}, r.addr, base + 32'(i));
        if (exp_n == 1) begin
          check_output({tag, "_wr_data"}, r.data, exp_data);
          check_output({tag, "_wr_size"}, 32'(r.size), 32'(sz));
        end else begin
          check_output({tag, "_wr_byte"}, {24'd0, r.data[7:0]}, {24'd0, exp_data[8*i +: 8]});
          check_output({tag, "_wr_size"}, 32'(r.size), 32'(BYTE));
        end
      end
    end
  endtask

  initial begin
    int start;
    int r0;
    int a0;
    wr_rec_t r;

    rst       = 1'b1;
    mem_clear = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = BYTE;
    req_sz_ex = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst_resp_err", 32'(resp_err), 32'd0);
    check_output("rst_resp_rdata", resp_rdata, 32'd0);
    check_output("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check_output("rst_mem_address", mem_address, 32'd0);
    check_output("rst_mem_data_in", mem_data_in, 32'd0);
    check_output("rst_mem_size", 32'(mem_size), 32'(WORD));
    check_output("rst_mem_sz_ex", 32'(mem_sz_ex), 32'd0);
    rst       = 1'b0;
    mem_clear = 1'b0;

    start = wr_log.size();
    do_req("st_w8", 1'b1, 32'd8, 32'h11223344, WORD, 1'b0, 32'h0, 1'b0, 3);
    check_writes("st_w8", start, 1, 32'd8, 32'h11223344, WORD);

    start = wr_log.size();
    do_req("ld_w8", 1'b0, 32'd8, 32'h0, WORD, 1'b0, 32'h11223344, 1'b0, 3);
    check_writes("ld_w8", start, 0, 32'd0, 32'h0, WORD);

    start = wr_log.size();
    do_req("st_w13", 1'b1, 32'd13, 32'hAABBCCDD, WORD, 1'b0, 32'h0, 1'b0, 6);
    check_writes("st_w13", start, 4, 32'd13, 32'hAABBCCDD, BYTE);

    do_req("ld_w13", 1'b0, 32'd13, 32'h0, WORD, 1'b0, 32'hAABBCCDD, 1'b0, 6);

    start = wr_log.size();
    do_req("st_h15", 1'b1, 32'd15, 32'h00009234, HALF_WORD, 1'b0, 32'h0, 1'b0, 4);
    check_writes("st_h15", start, 2, 32'd15, 32'h00009234, BYTE);

    do_req("ld_h15_sx", 1'b0, 32'd15, 32'h0, HALF_WORD, 1'b1, 32'hFFFF9234, 1'b0, 4);
    do_req("ld_h15_zx", 1'b0, 32'd15, 32'h0, HALF_WORD, 1'b0, 32'h00009234, 1'b0, 4);
    do_req("ld_b16_sx", 1'b0, 32'd16, 32'h0, BYTE, 1'b1, 32'hFFFFFF92, 1'b0, 3);

    do_req("st_b255", 1'b1, 32'd255, 32'h0000007E, BYTE, 1'b0, 32'h0, 1'b0, 3);
    do_req("ld_b255", 1'b0, 32'd255, 32'h0, BYTE, 1'b1, 32'h0000007E, 1'b0, 3);
    do_req("ld_h255_err", 1'b0, 32'd255, 32'h0, HALF_WORD, 1'b0, 32'h0, 1'b1, 2);

    start = wr_log.size();
    do_req("st_w254_err", 1'b1, 32'd254, 32'hDEADBEEF, WORD, 1'b0, 32'h0, 1'b1, 2);
    check_writes("st_w254_err", start, 0, 32'd0, 32'h0, WORD);

    // Abort a split store while its second byte is on the bus.
    start = wr_log.size();
    r0 = resp_cnt;
    apply_stimulus("rst_split", 1'b1, 32'd13, 32'h01020304, WORD, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_output("rst_split_ready", 32'(req_ready), 32'd1);
    check_output("rst_split_resp_valid", 32'(resp_valid), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check_output("rst_split_no_resp", 32'(resp_cnt - r0), 32'd0);
    check_writes("rst_split", start, 1, 32'd13, 32'h00000004, BYTE);
    check_output("rst_split_m13", {24'd0, mem[13]}, 32'h04);
    check_output("rst_split_m14", {24'd0, mem[14]}, 32'hCC);
    check_output("rst_split_m15", {24'd0, mem[15]}, 32'h34);
    check_output("rst_split_m16", {24'd0, mem[16]}, 32'h92);

    // Hold req_valid for 12 edges: byte stores take 4 cycles each, so 3 are accepted.
    @(negedge clk);
    start     = wr_log.size();
    a0        = accept_cnt;
    r0        = resp_cnt;
    req_wr    = 1'b1;
    req_addr  = 32'd40;
    req_wdata = 32'h0000005A;
    req_size  = BYTE;
    req_sz_ex = 1'b0;
    req_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1 req_valid = 1'b0;
    check_output("busy_accepts", 32'(accept_cnt - a0), 32'd3);
    check_output("busy_resps", 32'(resp_cnt - r0), 32'd3);
    check_output("busy_writes", 32'(wr_log.size() - start), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (start + i < wr_log.size()) begin
        r = wr_log[start + i];
        check_output("busy_wr_addr", r.addr, 32'd40);
      end
    end
    check_output("busy_m40", {24'd0, mem[40]}, 32'h5A);

    repeat (4) @(posedge clk);
    #1;
    check_output("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
